// File: rtl/dmem_responder.sv
// Word-addressed data memory answering MEM-stage loads/stores over valid/ready.
// Latency: response visible LATENCY cycles after acceptance; one request in flight, held until rsp_ready.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_wdata;
  logic              lat_err;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_idx_ext;
  logic              req_err;

  assign req_idx     = req_addr[ADDR_W+1:2];
  assign req_idx_ext = 32'(req_idx);
  assign req_err     = (req_addr[1:0] != 2'b00) ||
                       (req_addr[31:ADDR_W+2] != '0) ||
                       (req_idx_ext >= 32'(DEPTH));

  // With zero latency the access happens on the acceptance edge, straight from the request.
  logic              acc_we;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic              go_resp;

  assign acc_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign acc_idx   = (state == S_IDLE) ? req_idx   : lat_idx;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign acc_err   = (state == S_IDLE) ? req_err   : lat_err;
  assign go_resp   = ((state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_err   <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_err   <= req_err;
            if (LATENCY == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state   <= S_IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Errored accesses never touch the array.
      if (go_resp) begin
        if (acc_err) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end else if (acc_we) begin
          mem[acc_idx] <= acc_wdata;
          rdata_q      <= 32'd0;
        end else begin
          rdata_q <= mem[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder (LATENCY=2 main instance, LATENCY=0 directed instance).
module tb_dmem_responder;
  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
  logic [31:0] req_addr0 = 32'd0, req_wdata0 = 32'd0;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rsp_rdata0;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(5), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(5), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          bp_mode = 0;
  int          last_acc = 0;
  bit          have_last = 0;
  bit          seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom % 2);
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: every cycle a response is presented it must match the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen = 0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          chk("rsp_latency", cyc, exp_q[0].vis);
          seen = 1;
        end
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
        chk("resp_busy_ready", {30'd0, busy, req_ready}, 32'd2);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    have_last = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst0_req_ready", {31'd0, req_ready0}, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int   n = 0;
    exp_t e;
    bit   err;
    int   idx;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble request fields after acceptance; the responder must ignore them.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (have_last) chk("accept_gap", {31'd0, (cyc - last_acc) >= LAT + 2}, 32'd1);
    have_last = 1;
    last_acc  = cyc;
    err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    idx = int'(addr / 4);
    e.vis = cyc + LAT;
    e.err = err;
    if (err) begin
      e.rdata = 32'd0;
    end else if (we) begin
      model_mem[idx] = wd;
      e.rdata = 32'd0;
    end else begin
      e.rdata = model_mem[idx];
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    do_reset();
    issue(1'b0, 32'h0, 32'h0);
    drain();

    issue(1'b1, 32'hC, 32'hDEADBEEF);
    issue(1'b0, 32'hC, 32'h0);
    drain();

    // Backpressure: response must hold steady while rsp_ready stays low.
    issue(1'b1, 32'h4, 32'h5);
    drain();
    bp_mode = 2;
    issue(1'b0, 32'h4, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'd5);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    bp_mode = 0;
    n = 0;
    while (rsp_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_idle", {30'd0, req_ready, busy}, 32'd2);
    drain();

    issue(1'b1, 32'h6, 32'hBAD0BAD0);
    issue(1'b0, 32'h4, 32'h0);
    issue(1'b0, 32'h80, 32'h0);
    issue(1'b1, 32'h80000000, 32'h1);
    drain();

    // Reset while the store is still waiting: it must never commit.
    issue(1'b1, 32'h10, 32'h12345678);
    do_reset();
    issue(1'b0, 32'h10, 32'h0);
    drain();

    bp_mode = 1;
    for (int t = 0; t < 150; t++) begin
      case ($urandom % 8)
        0, 1, 2, 3, 4: a = 32'($urandom % DEPTH) * 4;
        5:             a = (32'($urandom % DEPTH) * 4) | 32'($urandom_range(1, 3));
        6:             a = $urandom | 32'h0000_0100;
        default:       a = 4 * DEPTH + 4 * 32'($urandom % 4);
      endcase
      issue(1'($urandom), a, $urandom);
      repeat ($urandom % 3) @(negedge clk);
    end
    bp_mode = 0;
    drain();

    // Zero-latency instance: response right after acceptance, next accept two edges later.
    @(negedge clk);
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'h0000A5A5;
    @(negedge clk);
    chk("l0_store_vld", {31'd0, rsp_valid0}, 32'd1);
    chk("l0_store_rdata", rsp_rdata0, 32'd0);
    chk("l0_store_busy_rdy", {30'd0, busy0, req_ready0}, 32'd2);
    req_we0 = 1'b0;
    @(negedge clk);
    chk("l0_idle_after", {30'd0, req_ready0, rsp_valid0}, 32'd2);
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("l0_load_vld", {31'd0, rsp_valid0}, 32'd1);
    chk("l0_load_rdata", rsp_rdata0, 32'h0000A5A5);
    chk("l0_load_err", {31'd0, rsp_err0}, 32'd0);
    @(negedge clk);
    req_valid0 = 1'b1; req_addr0 = 32'h81;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("l0_err_flag", {31'd0, rsp_err0}, 32'd1);
    chk("l0_err_rdata", rsp_rdata0, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
